// File: rtl/apple1_pia.sv
// apple1_pia
//   6821-style PIA for the Apple-1 CPU bus ($D010-$D013). The CPU side
//   only acts on cpu_clken_i strobes (1 MHz bus rate). Keys from the PS/2
//   decoder are buffered in a small FIFO. Display characters go to the
//   video terminal over a valid/ready handshake.
//
// Ports
//   clk25_i      25 MHz master clock, the only clock
//   rst_i        synchronous active-high reset
//   cpu_clken_i  one-cycle CPU bus strobe
//   cs_i         PIA selected this bus cycle
//   we_i         1 = write, 0 = read
//   addr_i       0 KBD, 1 KBDCR, 2 DSP, 3 DSPCR
//   din_i        CPU write data
//   dout_o       CPU read data, registered on the read strobe
//   kbd_valid_i  key byte offered by the PS/2 decoder
//   kbd_data_i   ASCII key code
//   kbd_ready_o  FIFO can accept a key (not full)
//   dsp_valid_o  character pending for the terminal
//   dsp_data_o   character to the terminal
//   dsp_ready_i  terminal accepts the character
module apple1_pia #(
    parameter int FIFO_AW = 2
) (
    input  logic       clk25_i,
    input  logic       rst_i,
    input  logic       cpu_clken_i,
    input  logic       cs_i,
    input  logic       we_i,
    input  logic [1:0] addr_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    input  logic       kbd_valid_i,
    input  logic [7:0] kbd_data_i,
    output logic       kbd_ready_o,
    output logic       dsp_valid_o,
    output logic [6:0] dsp_data_o,
    input  logic       dsp_ready_i
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    logic [6:0]         fifo_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [7:0]         dout_q, dout_d;
    logic [6:0]         kbdcr_q, kbdcr_d;
    logic [7:0]         dspcr_q, dspcr_d;
    logic               dsp_valid_q, dsp_valid_d;
    logic [6:0]         dsp_data_q, dsp_data_d;

    logic       rd, wr, full, empty, push, pop, dsp_accept;
    logic [6:0] key_up, head;
    logic [7:0] rd_data;

    assign rd    = cs_i & ~we_i & cpu_clken_i;
    assign wr    = cs_i &  we_i & cpu_clken_i;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign head  = fifo_q[rptr_q];

    // A full FIFO never offers ready, so push and pop cannot overflow together.
    assign push = kbd_valid_i & ~full;
    assign pop  = rd & (addr_i == 2'd0) & ~empty;

    // Lower-case letters are folded to upper case; the Apple-1 has no lower case.
    always_comb begin
        key_up = kbd_data_i[6:0];
        if (kbd_data_i[6:0] >= 7'h61 && kbd_data_i[6:0] <= 7'h7A)
            key_up = kbd_data_i[6:0] - 7'h20;
    end

    // A new character may replace one that the terminal takes on this edge.
    assign dsp_accept = wr & (addr_i == 2'd2) & (~dsp_valid_q | dsp_ready_i);

    always_comb begin
        rd_data = 8'h00;
        case (addr_i)
            2'd0: rd_data = empty ? 8'h80 : {1'b1, head};
            2'd1: rd_data = {~empty, kbdcr_q};
            2'd2: rd_data = {dsp_valid_q, 7'b0};
            2'd3: rd_data = dspcr_q;
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        wptr_d      = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d      = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d     = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;

        dout_d      = rd ? rd_data : dout_q;
        kbdcr_d     = (wr && addr_i == 2'd1) ? din_i[6:0] : kbdcr_q;
        dspcr_d     = (wr && addr_i == 2'd3) ? din_i : dspcr_q;

        dsp_valid_d = dsp_valid_q;
        dsp_data_d  = dsp_data_q;
        if (dsp_accept) begin
            dsp_valid_d = 1'b1;
            dsp_data_d  = din_i[6:0];
        end else if (dsp_valid_q && dsp_ready_i) begin
            dsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk25_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            dout_q      <= 8'h00;
            kbdcr_q     <= 7'h00;
            dspcr_q     <= 8'h00;
            dsp_valid_q <= 1'b0;
            dsp_data_q  <= 7'h00;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            kbdcr_q     <= kbdcr_d;
            dspcr_q     <= dspcr_d;
            dsp_valid_q <= dsp_valid_d;
            dsp_data_q  <= dsp_data_d;
        end
    end

    // Storage needs no reset: reset empties the FIFO through the pointers.
    always_ff @(posedge clk25_i) begin
        if (push && !rst_i)
            fifo_q[wptr_q] <= key_up;
    end

    assign dout_o      = dout_q;
    assign kbd_ready_o = ~full;
    assign dsp_valid_o = dsp_valid_q;
    assign dsp_data_o  = dsp_data_q;

endmodule

// File: tb/tb_apple1_pia.sv
// Scoreboard bench for apple1_pia: stimulus tasks queue expected values,
// a negedge monitor pops and compares them against the DUT.
module tb_apple1_pia;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clken = 1'b0, cs = 1'b0, we = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       kbd_valid = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_ready, dsp_valid;
    logic [6:0] dsp_data;
    logic       dsp_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // sel: 0 dout, 1 dsp_valid, 2 dsp_data, 3 kbd_ready
    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } chk_t;
    chk_t sb[$];

    apple1_pia #(.FIFO_AW(2)) dut (
        .clk25_i    (clk),
        .rst_i      (rst),
        .cpu_clken_i(clken),
        .cs_i       (cs),
        .we_i       (we),
        .addr_i     (addr),
        .din_i      (din),
        .dout_o     (dout),
        .kbd_valid_i(kbd_valid),
        .kbd_data_i (kbd_data),
        .kbd_ready_o(kbd_ready),
        .dsp_valid_o(dsp_valid),
        .dsp_data_o (dsp_data),
        .dsp_ready_i(dsp_ready)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t e;
            logic [7:0] act;
            e = sb.pop_front();
            case (e.sel)
                0: act = dout;
                1: act = {7'b0, dsp_valid};
                2: act = {1'b0, dsp_data};
                default: act = {7'b0, kbd_ready};
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_v(input string name, input int sel, input logic [7:0] exp);
        chk_t e;
        e.name = name; e.sel = sel; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic bus(input logic w, input logic [1:0] a, input logic [7:0] d);
        step();
        cs = 1'b1; we = w; addr = a; din = d; clken = 1'b1;
        step();
        cs = 1'b0; we = 1'b0; clken = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        bus(1'b0, a, 8'h00);
        expect_v(name, 0, exp);
        step();
    endtask

    task automatic key(input logic [7:0] k);
        step();
        kbd_valid = 1'b1; kbd_data = k;
        step();
        kbd_valid = 1'b0;
    endtask

    initial begin : stim
        // Reset
        step(); step();
        rst = 1'b0;
        expect_v("rst_dout", 0, 8'h00);
        expect_v("rst_dsp_valid", 1, 8'h00);
        expect_v("rst_dsp_data", 2, 8'h00);
        expect_v("rst_kbd_ready", 3, 8'h01);
        step();
        rd_chk("rst_kbdcr", 2'd1, 8'h00);

        // Single key, case folding
        key(8'h61);
        rd_chk("kbdcr_avail", 2'd1, 8'h80);
        rd_chk("kbd_a", 2'd0, 8'hC1);
        rd_chk("kbd_empty", 2'd0, 8'h80);

        // Fill, overflow attempt, drain with pointer wrap
        key(8'h31); key(8'h32); key(8'h33); key(8'h34);
        expect_v("full_ready", 3, 8'h00);
        step();
        key(8'h35);
        rd_chk("fifo0", 2'd0, 8'hB1);
        expect_v("ready_after_pop", 3, 8'h01);
        rd_chk("fifo1", 2'd0, 8'hB2);
        rd_chk("fifo2", 2'd0, 8'hB3);
        rd_chk("fifo3", 2'd0, 8'hB4);
        rd_chk("fifo_drained", 2'd0, 8'h80);

        // Case-folding boundaries
        key(8'h7A); key(8'h60); key(8'h7B); key(8'hE1);
        rd_chk("fold_z", 2'd0, 8'hDA);
        rd_chk("keep_60", 2'd0, 8'hE0);
        rd_chk("keep_7b", 2'd0, 8'hFB);
        rd_chk("fold_bit7", 2'd0, 8'hC1);

        // Simultaneous push and pop
        key(8'h41); key(8'h42);
        step();
        kbd_valid = 1'b1; kbd_data = 8'h43;
        cs = 1'b1; we = 1'b0; addr = 2'd0; clken = 1'b1;
        step();
        kbd_valid = 1'b0; cs = 1'b0; clken = 1'b0;
        expect_v("pushpop_head", 0, 8'hC1);
        step();
        rd_chk("pushpop_1", 2'd0, 8'hC2);
        rd_chk("pushpop_2", 2'd0, 8'hC3);
        rd_chk("pushpop_empty", 2'd0, 8'h80);

        // Control registers and ignored KBD write
        bus(1'b1, 2'd1, 8'hFF);
        rd_chk("kbdcr_wr", 2'd1, 8'h7F);
        bus(1'b1, 2'd3, 8'hA5);
        rd_chk("dspcr_wr", 2'd3, 8'hA5);
        bus(1'b1, 2'd0, 8'h55);
        rd_chk("kbd_wr_ignored", 2'd0, 8'h80);
        rd_chk("dsp_idle", 2'd2, 8'h00);

        // Display handshake
        bus(1'b1, 2'd2, 8'h8D);
        expect_v("dsp_valid_set", 1, 8'h01);
        expect_v("dsp_data_0d", 2, 8'h0D);
        step();
        rd_chk("dsp_busy", 2'd2, 8'h80);
        bus(1'b1, 2'd2, 8'hC1);
        expect_v("dsp_drop", 2, 8'h0D);
        step();
        dsp_ready = 1'b1;
        step();
        dsp_ready = 1'b0;
        expect_v("dsp_taken", 1, 8'h00);
        step();

        // Replace on the accepting edge
        bus(1'b1, 2'd2, 8'h41);
        expect_v("dsp_valid_41", 1, 8'h01);
        step();
        cs = 1'b1; we = 1'b1; addr = 2'd2; din = 8'hC2; clken = 1'b1; dsp_ready = 1'b1;
        step();
        cs = 1'b0; we = 1'b0; clken = 1'b0; dsp_ready = 1'b0;
        expect_v("dsp_valid_hold", 1, 8'h01);
        expect_v("dsp_data_42", 2, 8'h42);
        step();

        // Reset mid-transfer with a key buffered
        key(8'h39);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_v("rst2_dsp_valid", 1, 8'h00);
        expect_v("rst2_dout", 0, 8'h00);
        expect_v("rst2_ready", 3, 8'h01);
        step();
        rd_chk("rst2_fifo_flushed", 2'd0, 8'h80);
        rd_chk("rst2_kbdcr", 2'd1, 8'h00);

        // Drain scoreboard, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
